ctrl_sequencer: RTL and testbench



---
 rtl/ctrl_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Hardwired microsequencer: fetch/decode/execute over C0-C15 gates and bus handshake.
// Optional single-step control enabled by defining CTRL_SEQ_SINGLE_STEP_EN.
module ctrl_sequencer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int OPC_W        = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
   input  logic             i_step_mode,
   input  logic             i_step,
`endif
   input  logic [OPC_W-1:0] i_opcode,
   input  logic [4:0]       i_flags,
   input  logic             i_mem_ready,
   output logic [15:0]      o_ctrl,
   output logic [3:0]       o_alu_op,
   output logic             o_ctrl_halt,
   output logic             o_mar_inc,
   output logic             o_pc_inc,
   output logic             o_mem_rd,
   output logic             o_mem_wr,
   output logic             o_fault,
   output logic [3:0]       o_state
);

   typedef enum logic [3:0] {
      ST_F0   = 4'd0,
      ST_F1   = 4'd1,
      ST_F2   = 4'd2,
      ST_DEC  = 4'd3,
      ST_S0   = 4'd4,
      ST_S1   = 4'd5,
      ST_L0   = 4'd6,
      ST_L1   = 4'd7,
      ST_A0   = 4'd8,
      ST_A1   = 4'd9,
      ST_A2   = 4'd10,
      ST_J0   = 4'd11,
      ST_HALT = 4'd12
   } state_t;

   localparam logic [3:0] W_LAST = 4'(MEM_WAIT_MAX - 1);

   localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_JGEZ  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(9);

   state_t      r_state;
   logic        r_go;
   logic [3:0]  r_wait;
   logic [2:0]  r_aluop;
   logic [15:0] r_ctrl;
   logic [3:0]  r_alu;
   logic        r_halt;
   logic        r_pci;
   logic        r_rd;
   logic        r_wr;
   logic        r_fault;

   state_t      w_next;
   logic        w_go_next;
   logic        w_req;
   logic        w_tmo;
   logic        w_f0_ok;
   logic [2:0]  w_aluop;
   logic [15:0] w_ctrl_d;
   logic [3:0]  w_alu_d;
   logic        w_halt_d;
   logic        w_pci_d;
   logic        w_rd_d;
   logic        w_wr_d;
   logic        w_unused_flags;

   assign w_unused_flags = ^{i_flags[4:2], i_flags[0]};

`ifdef CTRL_SEQ_SINGLE_STEP_EN
   logic r_step_q;

   // Delay i_step by one cycle to detect its rising edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_step_q <= 1'b0;
      else          r_step_q <= i_step;
   end

   assign w_f0_ok = ~i_step_mode | (i_step & ~r_step_q);
`else
   assign w_f0_ok = 1'b1;
`endif

   assign w_req = (r_state == ST_F1) | (r_state == ST_L0) |
                  (r_state == ST_A0) | (r_state == ST_S1);
   assign w_tmo = w_req & ~i_mem_ready & (r_wait == W_LAST);

   // ALU op for the arithmetic/logic opcodes, captured in DEC
   always_comb begin
      w_aluop = 3'b000;
      unique case (1'b1)
         (i_opcode == OP_SUB): w_aluop = 3'b001;
         (i_opcode == OP_AND): w_aluop = 3'b010;
         (i_opcode == OP_OR):  w_aluop = 3'b011;
         default:              w_aluop = 3'b000;
      endcase
   end

   // Next-state selection; an F0 entered with r_go low idles with no gates
   always_comb begin
      w_next    = r_state;
      w_go_next = r_go;
      unique case (r_state)
         ST_F0: begin
            if (r_go) begin
               w_next    = ST_F1;
               w_go_next = 1'b0;
            end else begin
               w_go_next = w_f0_ok;
            end
         end
         ST_F1:  w_next = i_mem_ready ? ST_F2 : ST_F1;
         ST_F2:  w_next = ST_DEC;
         ST_DEC: begin
            unique case (1'b1)
               (i_opcode == OP_STORE): w_next = ST_S0;
               (i_opcode == OP_LOAD):  w_next = ST_L0;
               (i_opcode == OP_ADD),
               (i_opcode == OP_SUB),
               (i_opcode == OP_AND),
               (i_opcode == OP_OR):    w_next = ST_A0;
               (i_opcode == OP_JGEZ):
                  w_next = i_flags[1] ? ST_F0 : ST_J0;
               (i_opcode == OP_JMP):   w_next = ST_J0;
               (i_opcode == OP_HALT):  w_next = ST_HALT;
               default:                w_next = ST_F0;
            endcase
         end
         ST_S0:   w_next = ST_S1;
         ST_S1:   w_next = i_mem_ready ? ST_F0 : ST_S1;
         ST_L0:   w_next = i_mem_ready ? ST_L1 : ST_L0;
         ST_L1:   w_next = ST_F0;
         ST_A0:   w_next = i_mem_ready ? ST_A1 : ST_A0;
         ST_A1:   w_next = ST_A2;
         ST_A2:   w_next = ST_F0;
         ST_J0:   w_next = ST_F0;
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_F0;
      endcase
      if (w_tmo) w_next = ST_HALT;
      if (w_next == ST_F0 && r_state != ST_F0) w_go_next = w_f0_ok;
   end

   // Moore output decode of the state being entered
   always_comb begin
      w_ctrl_d = 16'h0000;
      w_alu_d  = 4'h0;
      w_halt_d = 1'b0;
      w_pci_d  = 1'b0;
      w_rd_d   = 1'b0;
      w_wr_d   = 1'b0;
      unique case (w_next)
         ST_F0:   w_ctrl_d[2] = w_go_next;
         ST_F1: begin
            w_ctrl_d[5] = 1'b1;
            w_rd_d      = 1'b1;
            w_pci_d     = 1'b1;
         end
         ST_F2:   w_ctrl_d[4] = 1'b1;
         ST_DEC: begin
            w_ctrl_d[14] = 1'b1;
            w_ctrl_d[8]  = 1'b1;
         end
         ST_S0:   w_ctrl_d[12] = 1'b1;
         ST_S1: begin
            w_ctrl_d[13] = 1'b1;
            w_wr_d       = 1'b1;
         end
         ST_L0, ST_A0: begin
            w_ctrl_d[5] = 1'b1;
            w_rd_d      = 1'b1;
         end
         ST_L1:   w_ctrl_d[11] = 1'b1;
         ST_A1: begin
            w_ctrl_d[6] = 1'b1;
            w_ctrl_d[7] = 1'b1;
            w_alu_d     = {1'b1, r_aluop};
         end
         ST_A2:   w_ctrl_d[9] = 1'b1;
         ST_J0:   w_ctrl_d[3] = 1'b1;
         ST_HALT: w_halt_d = 1'b1;
         default: w_ctrl_d = 16'h0000;
      endcase
   end

   // Sequencer state, wait counter, fault flag and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_F0;
         r_go    <= 1'b0;
         r_wait  <= 4'd0;
         r_aluop <= 3'b000;
         r_ctrl  <= 16'h0000;
         r_alu   <= 4'h0;
         r_halt  <= 1'b0;
         r_pci   <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         r_go    <= w_go_next;
         if (w_next != r_state)
            r_wait <= 4'd0;
         else if (w_req && !i_mem_ready)
            r_wait <= r_wait + 4'd1;
         if (r_state == ST_DEC) r_aluop <= w_aluop;
         r_ctrl  <= w_ctrl_d;
         r_alu   <= w_alu_d;
         r_halt  <= w_halt_d;
         r_pci   <= w_pci_d;
         r_rd    <= w_rd_d;
         r_wr    <= w_wr_d;
         r_fault <= r_fault | w_tmo;
      end
   end

   // Bus-capture gate and PC strobe fire only in the cycle the bus completes
   assign o_ctrl      = {r_ctrl[15:6], r_ctrl[5] & i_mem_ready, r_ctrl[4:0]};
   assign o_pc_inc    = r_pci & i_mem_ready;
   assign o_alu_op    = r_alu;
   assign o_ctrl_halt = r_halt;
   assign o_mar_inc   = 1'b0;
   assign o_mem_rd    = r_rd;
   assign o_mem_wr    = r_wr;
   assign o_fault     = r_fault;
   assign o_state     = r_state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer.
// Each task drives one scenario and checks against hand-computed values.
module tb_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  opcode = 8'h00;
   logic [4:0]  flags = 5'h00;
   logic        ready = 1'b0;
   logic [15:0] o_ctrl;
   logic [3:0]  o_alu_op;
   logic        o_ctrl_halt;
   logic        o_mar_inc;
   logic        o_pc_inc;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic        o_fault;
   logic [3:0]  o_state;

   int errors = 0;
   int checks = 0;

   ctrl_sequencer #(.MEM_WAIT_MAX(15), .OPC_W(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_opcode    (opcode),
      .i_flags     (flags),
      .i_mem_ready (ready),
      .o_ctrl      (o_ctrl),
      .o_alu_op    (o_alu_op),
      .o_ctrl_halt (o_ctrl_halt),
      .o_mar_inc   (o_mar_inc),
      .o_pc_inc    (o_pc_inc),
      .o_mem_rd    (o_mem_rd),
      .o_mem_wr    (o_mem_wr),
      .o_fault     (o_fault),
      .o_state     (o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in F0 with C2 visible
   task automatic do_reset();
      rst_n = 1'b0;
      ready = 1'b0;
      #1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] all;
      rst_n = 1'b0;
      repeat (3) tick();
      all = {o_ctrl, o_alu_op, o_ctrl_halt, o_mar_inc, o_pc_inc,
             o_mem_rd, o_mem_wr, o_fault, o_state};
      checks++;
      if (all !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", all);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (o_ctrl !== 16'h0004) begin
         errors++;
         $display("FAIL reset_release_c2: o_ctrl=%h expected 0004", o_ctrl);
      end
      tick();
      checks++;
      if (o_mem_rd !== 1'b1 || o_state !== 4'd1) begin
         errors++;
         $display("FAIL f1_request: rd=%b state=%0d expected rd=1 state=1",
                  o_mem_rd, o_state);
      end
      rst_n = 1'b0;
      #1;
      all = {o_ctrl, o_alu_op, o_ctrl_halt, o_mar_inc, o_pc_inc,
             o_mem_rd, o_mem_wr, o_fault, o_state};
      checks++;
      if (all !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_f1: got %h expected 0", all);
      end
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (o_ctrl !== 16'h0004 || o_mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_f1_release: o_ctrl=%h rd=%b expected 0004 0",
                  o_ctrl, o_mem_rd);
      end
   endtask

   task automatic test_load();
      logic [15:0] exp [7] = '{16'h0004, 16'h0020, 16'h0010, 16'h4100,
                               16'h0020, 16'h0800, 16'h0004};
      opcode = 8'h02;
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (o_ctrl !== exp[i] || o_pc_inc !== (i == 1)) begin
            errors++;
            $display("FAIL load_step%0d: o_ctrl=%h pc_inc=%b expected %h %b",
                     i, o_ctrl, o_pc_inc, exp[i], (i == 1));
         end
         tick();
      end
   endtask

   task automatic test_store();
      logic [15:0] exp [7] = '{16'h0004, 16'h0020, 16'h0010, 16'h4100,
                               16'h1000, 16'h2000, 16'h0004};
      opcode = 8'h01;
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (o_ctrl !== exp[i] || o_mem_wr !== (i == 5)) begin
            errors++;
            $display("FAIL store_step%0d: o_ctrl=%h wr=%b expected %h %b",
                     i, o_ctrl, o_mem_wr, exp[i], (i == 5));
         end
         tick();
      end
   endtask

   task automatic test_sub_wait();
      int n;
      opcode = 8'h04;
      do_reset();
      ready = 1'b1;
      repeat (3) tick();
      ready = 1'b0;
      tick();
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) ready = 1'b1;
         #1;
         if (o_mem_rd === 1'b1) n++;
         if (k == 3) begin
            checks++;
            if (o_ctrl !== 16'h0020) begin
               errors++;
               $display("FAIL sub_a0_ready: o_ctrl=%h expected 0020", o_ctrl);
            end
         end
         tick();
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL sub_rd_held: cycles=%0d expected 4", n);
      end
      checks++;
      if (o_alu_op !== 4'b1001 || o_ctrl !== 16'h00C0 || o_mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL sub_a1: alu=%b ctrl=%h rd=%b expected 1001 00c0 0",
                  o_alu_op, o_ctrl, o_mem_rd);
      end
      tick();
      checks++;
      if (o_ctrl !== 16'h0200 || o_alu_op !== 4'b0000) begin
         errors++;
         $display("FAIL sub_a2: ctrl=%h alu=%b expected 0200 0000",
                  o_ctrl, o_alu_op);
      end
      tick();
      checks++;
      if (o_ctrl !== 16'h0004) begin
         errors++;
         $display("FAIL sub_back_f0: ctrl=%h expected 0004", o_ctrl);
      end
   endtask

   task automatic test_alu_ops();
      logic [7:0] ops [3]  = '{8'h03, 8'h08, 8'h09};
      logic [3:0] alus [3] = '{4'b1000, 4'b1010, 4'b1011};
      for (int i = 0; i < 3; i++) begin
         opcode = ops[i];
         do_reset();
         ready = 1'b1;
         repeat (5) tick();
         checks++;
         if (o_alu_op !== alus[i] || o_ctrl !== 16'h00C0) begin
            errors++;
            $display("FAIL alu_op_%h: alu=%b ctrl=%h expected %b 00c0",
                     ops[i], o_alu_op, o_ctrl, alus[i]);
         end
      end
   endtask

   task automatic test_jmpgez();
      logic c3;
      opcode = 8'h05;
      flags = 5'b00010;
      do_reset();
      ready = 1'b1;
      c3 = 1'b0;
      repeat (4) begin
         tick();
         if (o_ctrl[3] === 1'b1) c3 = 1'b1;
      end
      checks++;
      if (c3 !== 1'b0 || o_state !== 4'd0 || o_ctrl !== 16'h0004) begin
         errors++;
         $display("FAIL jgez_neg: c3=%b state=%0d ctrl=%h expected 0 0 0004",
                  c3, o_state, o_ctrl);
      end
      flags = 5'b00000;
      repeat (4) tick();
      checks++;
      if (o_ctrl !== 16'h0008 || o_state !== 4'd11) begin
         errors++;
         $display("FAIL jgez_taken: ctrl=%h state=%0d expected 0008 11",
                  o_ctrl, o_state);
      end
      tick();
      checks++;
      if (o_ctrl !== 16'h0004) begin
         errors++;
         $display("FAIL jgez_one_cycle: ctrl=%h expected 0004", o_ctrl);
      end
   endtask

   task automatic test_jmp();
      int n;
      opcode = 8'h06;
      flags = 5'b00010;
      do_reset();
      ready = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (o_state !== 4'd0 && n < 20);
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL jmp_cycles: got %0d expected 5", n);
      end
   endtask

   task automatic test_timeout();
      int n;
      opcode = 8'h02;
      do_reset();
      ready = 1'b0;
      tick();
      n = 0;
      while (o_mem_rd === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL timeout_wait: got %0d cycles expected 15", n);
      end
      checks++;
      if (o_fault !== 1'b1 || o_ctrl_halt !== 1'b1 || o_mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: fault=%b halt=%b rd=%b expected 1 1 0",
                  o_fault, o_ctrl_halt, o_mem_rd);
      end
      ready = 1'b1;
      repeat (20) tick();
      checks++;
      if (o_fault !== 1'b1 || o_ctrl_halt !== 1'b1 || o_state !== 4'd12) begin
         errors++;
         $display("FAIL timeout_sticky: fault=%b halt=%b state=%0d expected 1 1 12",
                  o_fault, o_ctrl_halt, o_state);
      end
   endtask

   task automatic test_halt();
      int bad;
      opcode = 8'h07;
      do_reset();
      ready = 1'b1;
      repeat (4) tick();
      checks++;
      if (o_ctrl_halt !== 1'b1 || o_fault !== 1'b0) begin
         errors++;
         $display("FAIL halt_entry: halt=%b fault=%b expected 1 0",
                  o_ctrl_halt, o_fault);
      end
      bad = 0;
      for (int i = 0; i < 110; i++) begin
         tick();
         if (o_ctrl_halt !== 1'b1 || o_mem_rd !== 1'b0 ||
             o_mem_wr !== 1'b0 || o_ctrl !== 16'h0000)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: bad cycles=%0d expected 0", bad);
      end
   endtask

   task automatic test_nop();
      opcode = 8'hFF;
      do_reset();
      checks++;
      if (o_fault !== 1'b0 || o_ctrl_halt !== 1'b0) begin
         errors++;
         $display("FAIL nop_reset_clear: fault=%b halt=%b expected 0 0",
                  o_fault, o_ctrl_halt);
      end
      ready = 1'b1;
      repeat (4) tick();
      checks++;
      if (o_ctrl !== 16'h0004 || o_state !== 4'd0) begin
         errors++;
         $display("FAIL nop_return: ctrl=%h state=%0d expected 0004 0",
                  o_ctrl, o_state);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_sub_wait();
      test_alu_ops();
      test_jmpgez();
      test_jmp();
      test_timeout();
      test_halt();
      test_nop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
